ram_handshake_responder: RTL
============================

# ram_handshake_responder

Byte-addressed, big-endian data/instruction memory that answers the datapath's MFA/MFC memory handshake. It latches a request when MFA is sampled high, waits a fixed number of wait states, performs one read or write of byte, halfword or word size, then asserts MFC until MFA is released. It sits inside data_path as the memory target of the MAR/MDR path. Its array stays hierarchically preloadable by testbenches.

## Interface
- WAIT_STATES, 2: extra cycles between request capture and completion; legal range 0–15.
- ADDR_WIDTH, 8: byte-address width; the array holds 2**ADDR_WIDTH bytes.
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- MFA  input  1  memory function active; the request is held high until MFC is seen.
- RW  input  1  1 = write, 0 = read.
- DSS  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- Address  input  ADDR_WIDTH  byte address.
- DataIn  input  32  write data, right-justified for byte and halfword accesses.
- DataOut  output  32  read data, registered.
- MFC  output  1  memory function complete, registered.

## Operation
- Storage: byte array `Mem[0:2**ADDR_WIDTH-1]`, 8 bits per entry, not cleared by reset.
- Big-endian layout: word at A occupies Mem[A]=bits 31:24 through Mem[A+3]=bits 7:0. Halfword at A occupies Mem[A]=15:8 and Mem[A+1]=7:0.
- Alignment: word accesses force Address[1:0]=0; halfword accesses force Address[0]=0. There is no misalignment fault.
- FSM states:
  - IDLE: MFC=0. If MFA=1, capture Address, RW, DSS and DataIn, load the counter with WAIT_STATES, and go to WAIT.
  - WAIT: if the counter is 0, perform the access and go to DONE. Otherwise decrement the counter.
  - DONE: MFC=1. Stay while MFA=1. When MFA=0, go to IDLE.
- Access is performed exactly once, on the WAIT→DONE edge, using the captured request.
  - Write: update only the selected bytes; other bytes are untouched.
  - Read: load DataOut with zero-extended data (byte into 7:0, halfword into 15:0, upper bits 0).
- DataOut holds its value until the next read completes. Writes do not change DataOut.
- Inputs changing during WAIT or DONE have no effect; only the captured copy is used.
- Address arithmetic is confined to the aligned base plus 0..3, so it never wraps past the top of the array.

## Timing
- Reset values: state IDLE, MFC=0, DataOut=32'h0, counter 0. Reset acts immediately and asynchronously.
- Reset mid-request: the request is abandoned. No write occurs unless the WAIT→DONE edge already happened.
- Latency: MFA sampled high at edge k gives MFC=1 and valid DataOut after edge k+1+WAIT_STATES.
  - With WAIT_STATES=0, this is the edge after capture.
- Release: MFA sampled low in DONE at edge m gives MFC=0 after edge m.
  - If MFA is sampled high at edge m+1, that is a new request.
  - Minimum spacing between request captures is WAIT_STATES+3 cycles.
- MFA held high continuously: MFC stays high. There is no second access until MFA drops and is re-sampled high in IDLE.
- MFA pulsed high for one cycle: the request is still captured and completed. MFC asserts and then drops one cycle later.

## Test plan
- Reset with MFA=0: MFC=0 and DataOut=0. Assert Reset low mid-WAIT of a word write of 32'hDEADBEEF to address 8 → Mem[8..11] unchanged, MFC=0, state returns to IDLE.
- Preload Mem[0..3]=8'h12,8'h34,8'h56,8'h78. Word read at 0 with WAIT_STATES=2, MFA at edge k → MFC high after edge k+3, DataOut=32'h12345678.
- Byte read at 2 → DataOut=32'h00000056. Halfword read at 3 → aligned to 2, DataOut=32'h00005678.
- Word write of 32'hA1B2C3D4 at 4, then byte write of 8'hFF at 6, then word read at 4 → 32'hA1B2FFD4.
  - Also check that a halfword write of 16'h0102 at 9 lands at Mem[8]=8'h01, Mem[9]=8'h02.
- Handshake: hold MFA high for 10 cycles → exactly one access, MFC stays high. Drop MFA → MFC low after one edge. Re-raise MFA → second completion after WAIT_STATES+1 edges.
- WAIT_STATES=0 and top address: word read at 8'hFF aligns to 8'hFC and returns Mem[FC..FF]. MFC is high one edge after capture.

Source files
------------

// File: rtl/ram_handshake_responder.sv
// rtl/ram_handshake_responder.sv - big-endian byte memory answering the MFA/MFC handshake
//
// Purpose: memory target of the MAR/MDR path. A request is captured when MFA
// is sampled high in IDLE. After WAIT_STATES extra cycles, one byte, halfword
// or word access is performed. MFC is then held high until MFA is released.
// The Mem array is not cleared by reset and stays hierarchically preloadable.
//
// Ports:
//   CLK      in   1           clock, rising edge
//   Reset    in   1           asynchronous active-low reset
//   MFA      in   1           memory function active (request)
//   RW       in   1           1 = write, 0 = read
//   DSS      in   2           size: 00 byte, 01 halfword, 1x word
//   Address  in   ADDR_WIDTH  byte address
//   DataIn   in   32          write data, right-justified
//   DataOut  out  32          registered read data, zero-extended
//   MFC      out  1           memory function complete, registered
module ram_handshake_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MFA,
  input  logic                  RW,
  input  logic [1:0]            DSS,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0]            cnt;
  logic                  req_rw;
  logic [1:0]            req_dss;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;

  logic [7:0] Mem [0:2**ADDR_WIDTH-1];

  logic                  do_access;
  logic                  is_word;
  logic                  is_half;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] a1;
  logic [ADDR_WIDTH-1:0] a2;
  logic [ADDR_WIDTH-1:0] a3;
  logic [31:0]           rd_data;

  // The single access happens on the WAIT->DONE edge.
  assign do_access = (state == S_WAIT) && (cnt == 4'd0);

  assign is_word = req_dss[1];
  assign is_half = (req_dss == 2'b01);

  // Alignment clears low address bits, so base|1..3 stays inside the
  // aligned group and never carries past the top of the array.
  assign align_mask = is_word ? ADDR_WIDTH'(3) : (is_half ? ADDR_WIDTH'(1) : '0);
  assign base       = req_addr & ~align_mask;
  assign a1         = base | ADDR_WIDTH'(1);
  assign a2         = base | ADDR_WIDTH'(2);
  assign a3         = base | ADDR_WIDTH'(3);

  always_comb begin
    rd_data = 32'h0;
    if (is_word) begin
      rd_data = {Mem[base], Mem[a1], Mem[a2], Mem[a3]};
    end else if (is_half) begin
      rd_data = {16'h0, Mem[base], Mem[a1]};
    end else begin
      rd_data = {24'h0, Mem[base]};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (MFA) next_state = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) next_state = S_DONE;
      S_DONE:  if (!MFA) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_rw   <= 1'b0;
      req_dss  <= 2'b00;
      req_addr <= '0;
      req_data <= 32'h0;
      DataOut  <= 32'h0;
      MFC      <= 1'b0;
    end else begin
      state <= next_state;
      MFC   <= (next_state == S_DONE);
      if (state == S_IDLE && MFA) begin
        cnt      <= 4'(WAIT_STATES);
        req_rw   <= RW;
        req_dss  <= DSS;
        req_addr <= Address;
        req_data <= DataIn;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access && !req_rw) begin
        DataOut <= rd_data;
      end
    end
  end

  // Storage has no reset; while Reset is low the FSM is held in IDLE, so
  // do_access is false and no write can slip through.
  always_ff @(posedge CLK) begin
    if (do_access && req_rw) begin
      if (is_word) begin
        Mem[base] <= req_data[31:24];
        Mem[a1]   <= req_data[23:16];
        Mem[a2]   <= req_data[15:8];
        Mem[a3]   <= req_data[7:0];
      end else if (is_half) begin
        Mem[base] <= req_data[15:8];
        Mem[a1]   <= req_data[7:0];
      end else begin
        Mem[base] <= req_data[7:0];
      end
    end
  end

endmodule
